// File: rtl/demux_pkg.sv
// Shared constants, state encoding and beat-slicing helper for the
// 32-to-8 serializer that undoes the 8-to-32 packer.
package demux_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int MAX_W      = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat k counted from the MSB end; the caller keeps the low beat_w bits.
  function automatic logic [MAX_W-1:0] beat_of(input logic [MAX_W-1:0] word,
                                               input int k,
                                               input int lanes,
                                               input int beat_w);
    beat_of = word >> ((lanes - 1 - k) * beat_w);
  endfunction

endpackage

// File: rtl/word_pend_buf.sv
// One-entry holding buffer for the word that arrives while another is
// still being serialized.
module word_pend_buf #(
  parameter int W = 32
) (
  input  logic         clk_4f,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  // Capture on load; clear takes priority so a drained entry frees up.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/demux_32_8.sv
// Serializes one BYTE_W*LANES word per handshake into LANES beats, MSB
// beat first, with a pending slot so consecutive words stream gaplessly.
module demux_32_8
  import demux_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic [BYTE_W*LANES-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [BYTE_W-1:0]       data_out,
  output logic                    valid_out,
  output logic                    busy
);

  localparam int WORD_W = BYTE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

  state_t              state_r, state_nxt_s;
  logic [WORD_W-1:0]   w_r, w_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [BYTE_W-1:0]   dout_nxt_s;
  logic                vout_nxt_s;
  logic                accept_s, last_s;
  logic                pend_load_s, pend_clr_s, pend_full_s;
  logic [WORD_W-1:0]   pend_word_s;
  logic [MAX_W-1:0]    beat_cur_s, beat_in_s, beat_pend_s;

  word_pend_buf #(.W(WORD_W)) u_pend (
    .clk_4f (clk_4f),
    .reset  (reset),
    .load   (pend_load_s),
    .clear  (pend_clr_s),
    .din    (data_in),
    .dout   (pend_word_s),
    .full   (pend_full_s)
  );

  assign ready_out = !pend_full_s && !reset;
  assign accept_s  = valid_in && ready_out;
  assign busy      = (state_r == SEND) || pend_full_s;
  assign last_s    = (cnt_r == LAST_CNT);

  assign beat_cur_s  = beat_of(MAX_W'(w_r), int'(cnt_r) + 1, LANES, BYTE_W);
  assign beat_in_s   = beat_of(MAX_W'(data_in), 0, LANES, BYTE_W);
  assign beat_pend_s = beat_of(MAX_W'(pend_word_s), 0, LANES, BYTE_W);

  // State register.
  always_ff @(posedge clk_4f) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state: leave SEND only after the last beat with nothing queued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SEND;
        else          state_nxt_s = IDLE;
      end
      SEND: begin
        if (last_s && !pend_full_s && !accept_s) state_nxt_s = IDLE;
        else                                     state_nxt_s = SEND;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values and pending-buffer control.
  always_comb begin
    w_nxt_s     = w_r;
    cnt_nxt_s   = cnt_r;
    dout_nxt_s  = data_out;
    vout_nxt_s  = valid_out;
    pend_load_s = 1'b0;
    pend_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        if (accept_s) begin
          w_nxt_s    = data_in;
          dout_nxt_s = beat_in_s[BYTE_W-1:0];
          vout_nxt_s = 1'b1;
        end else begin
          dout_nxt_s = '0;
          vout_nxt_s = 1'b0;
        end
      end
      SEND: begin
        if (!last_s) begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          dout_nxt_s  = beat_cur_s[BYTE_W-1:0];
          pend_load_s = accept_s;
        end else if (pend_full_s) begin
          w_nxt_s    = pend_word_s;
          dout_nxt_s = beat_pend_s[BYTE_W-1:0];
          cnt_nxt_s  = '0;
          pend_clr_s = 1'b1;
        end else if (accept_s) begin
          w_nxt_s    = data_in;
          dout_nxt_s = beat_in_s[BYTE_W-1:0];
          cnt_nxt_s  = '0;
        end else begin
          dout_nxt_s = '0;
          vout_nxt_s = 1'b0;
          cnt_nxt_s  = '0;
        end
      end
      default: begin
        dout_nxt_s = '0;
        vout_nxt_s = 1'b0;
        cnt_nxt_s  = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      w_r       <= '0;
      cnt_r     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      w_r       <= w_nxt_s;
      cnt_r     <= cnt_nxt_s;
      data_out  <= dout_nxt_s;
      valid_out <= vout_nxt_s;
    end
  end

endmodule

// File: tb/tb_demux_32_8.sv
// Directed bench for demux_32_8: default 4-lane instance plus a 2-lane one.
module tb_demux_32_8;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out, valid_out, busy;
  logic [7:0]  data_out;
  logic [15:0] data_in2;
  logic        valid_in2;
  logic        ready_out2, valid_out2, busy2;
  logic [7:0]  data_out2;

  int checks   = 0;
  int failures = 0;

  always #5 clk_4f = ~clk_4f;

  demux_32_8 dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .busy(busy)
  );

  demux_32_8 #(.BYTE_W(8), .LANES(2)) dut2 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in2), .valid_in(valid_in2),
    .ready_out(ready_out2), .data_out(data_out2), .valid_out(valid_out2), .busy(busy2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  // Advance one cycle and expect a valid beat on the 4-lane instance.
  task automatic beat(input string tag, input logic [7:0] exp);
    tick();
    check_val({tag, "_v"}, 32'(valid_out), 32'd1);
    check_val({tag, "_d"}, 32'(data_out), 32'(exp));
  endtask

  task automatic beat2(input string tag, input logic [7:0] exp);
    tick();
    check_val({tag, "_v"}, 32'(valid_out2), 32'd1);
    check_val({tag, "_d"}, 32'(data_out2), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 32'h0;
    valid_in2 = 1'b0; data_in2 = 16'h0;
    tick(); tick();
    check_val("rst_vout", 32'(valid_out), 32'd0);
    check_val("rst_dout", 32'(data_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(ready_out), 32'd0);
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(ready_out), 32'd1);

    // 1: single word
    data_in = 32'hAABBCCDD; valid_in = 1'b1;
    beat("w1_b0", 8'hAA);
    valid_in = 1'b0;
    beat("w1_b1", 8'hBB);
    beat("w1_b2", 8'hCC);
    beat("w1_b3", 8'hDD);
    tick();
    check_val("w1_idle_v", 32'(valid_out), 32'd0);
    check_val("w1_idle_d", 32'(data_out), 32'd0);
    check_val("w1_idle_busy", 32'(busy), 32'd0);
    check_val("w1_idle_ready", 32'(ready_out), 32'd1);

    // 2+3: back-to-back with a third word held off by backpressure
    data_in = 32'h11223344; valid_in = 1'b1;
    beat("bb_11", 8'h11);
    data_in = 32'h55667788;
    beat("bb_22", 8'h22);
    check_val("bb_ready_lo", 32'(ready_out), 32'd0);
    check_val("bb_busy", 32'(busy), 32'd1);
    data_in = 32'h99AABBCC;
    beat("bb_33", 8'h33);
    check_val("bp_ready_lo1", 32'(ready_out), 32'd0);
    beat("bb_44", 8'h44);
    check_val("bp_ready_lo2", 32'(ready_out), 32'd0);
    beat("bb_55", 8'h55);
    check_val("bb_ready_hi", 32'(ready_out), 32'd1);
    beat("bb_66", 8'h66);
    check_val("bp_accepted", 32'(ready_out), 32'd0);
    valid_in = 1'b0;
    beat("bb_77", 8'h77);
    beat("bb_88", 8'h88);
    beat("bp_99", 8'h99);
    beat("bp_AA", 8'hAA);
    beat("bp_BB", 8'hBB);
    beat("bp_CC", 8'hCC);
    tick();
    check_val("bb_idle_v", 32'(valid_out), 32'd0);
    check_val("bb_idle_busy", 32'(busy), 32'd0);

    // 4: valid_in dropped mid-word
    data_in = 32'hDEADBEEF; valid_in = 1'b1;
    beat("dv_DE", 8'hDE);
    valid_in = 1'b0; data_in = 32'h0;
    beat("dv_AD", 8'hAD);
    beat("dv_BE", 8'hBE);
    beat("dv_EF", 8'hEF);
    tick();
    check_val("dv_idle_v", 32'(valid_out), 32'd0);
    check_val("dv_idle_d", 32'(data_out), 32'd0);

    // 5: reset with beat 2 on output and a word pending
    data_in = 32'h01020304; valid_in = 1'b1;
    beat("rm_01", 8'h01);
    data_in = 32'h0A0B0C0D;
    beat("rm_02", 8'h02);
    check_val("rm_pending", 32'(ready_out), 32'd0);
    reset = 1'b1; valid_in = 1'b0;
    #1;
    check_val("rm_ready_in_rst", 32'(ready_out), 32'd0);
    tick();
    check_val("rm_vout", 32'(valid_out), 32'd0);
    check_val("rm_dout", 32'(data_out), 32'd0);
    check_val("rm_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("rm_no_emit", 32'(valid_out), 32'd0);
    end
    check_val("rm_ready_after", 32'(ready_out), 32'd1);

    // 6: two-lane instance, single then gapless pair
    data_in2 = 16'hABCD; valid_in2 = 1'b1;
    beat2("l2_AB", 8'hAB);
    data_in2 = 16'h1234;
    beat2("l2_CD", 8'hCD);
    check_val("l2_ready_lo", 32'(ready_out2), 32'd0);
    valid_in2 = 1'b0;
    beat2("l2_12", 8'h12);
    beat2("l2_34", 8'h34);
    tick();
    check_val("l2_idle_v", 32'(valid_out2), 32'd0);
    check_val("l2_idle_busy", 32'(busy2), 32'd0);
    check_val("l2_main_quiet", 32'(valid_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
